// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam logic RX_IDLE_LEVEL = 1'b1;

  // Centre of a bit period in oversample ticks (N/2).
  function automatic int unsigned mid_sample(input int unsigned width);
    return (32'd1 << width) >> 1;
  endfunction

endpackage

// File: rtl/slib_sync2.sv
// Two-flop synchroniser with asynchronous reset to a configurable level.
module slib_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= RESET_VAL;
      Q    <= RESET_VAL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start detection, 3-sample majority vote per bit,
// LSB-first frame assembly with framing-error and break handling.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BAUDCE,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 DVALID,
  output logic                 FERR,
  output logic                 BUSY
);

  localparam int unsigned MID = mid_sample(WIDTH);
  // cnt holds the value of the previous tick, so a sample "at value v" is
  // taken on the BAUDCE that finds cnt == v-1.
  localparam logic [WIDTH-1:0] CNT_SMP_A = WIDTH'(MID - 2);
  localparam logic [WIDTH-1:0] CNT_SMP_B = WIDTH'(MID - 1);
  localparam logic [WIDTH-1:0] CNT_VOTE  = WIDTH'(MID);
  localparam logic [WIDTH-1:0] CNT_LAST  = '1;
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rxs;
  rx_state_t            state;
  logic [WIDTH-1:0]     cnt;
  logic [2:0]           idx;
  logic                 smp_a;
  logic                 smp_b;
  logic                 vote;
  logic [DATA_BITS-1:0] shreg;

  slib_sync2 #(.RESET_VAL(RX_IDLE_LEVEL)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (RXD),
    .Q   (rxs)
  );

  assign vote = majority3(smp_a, smp_b, rxs);
  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      smp_a  <= RX_IDLE_LEVEL;
      smp_b  <= RX_IDLE_LEVEL;
      shreg  <= '0;
      DOUT   <= '0;
      DVALID <= 1'b0;
      FERR   <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      if (BAUDCE) begin
        if (state != IDLE) cnt <= cnt + 1'b1;
        if (cnt == CNT_SMP_A) smp_a <= rxs;
        if (cnt == CNT_SMP_B) smp_b <= rxs;
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_VOTE && vote) begin
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              state <= DATA;
              idx   <= '0;
            end
          end
          DATA: begin
            if (cnt == CNT_VOTE) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (cnt == CNT_LAST) begin
              if (idx == IDX_LAST) state <= STOP;
              else                 idx   <= idx + 1'b1;
            end
          end
          STOP: begin
            // Leave at the stop-bit centre so a back-to-back start edge is caught.
            if (cnt == CNT_VOTE) begin
              DOUT   <= shreg;
              DVALID <= 1'b1;
              FERR   <= ~vote;
              state  <= vote ? IDLE : BREAK;
            end
          end
          BREAK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at N=16, 8 data bits, BAUDCE every CLK.
module tb_uart_rx_sampler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BAUDCE = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       FERR;
  logic       BUSY;

  uart_rx_sampler #(.WIDTH(4), .DATA_BITS(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .BAUDCE (BAUDCE),
    .RXD    (RXD),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .FERR   (FERR),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] q_dout[$];
  logic       q_ferr[$];
  int         q_cyc[$];
  logic       prev_dv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Capture every completed frame; DVALID must never be high on two CLKs in a row.
  always @(negedge CLK) begin
    if (DVALID) begin
      chk("dvalid_single_pulse", {31'd0, prev_dv}, 32'd0);
      q_dout.push_back(DOUT);
      q_ferr.push_back(FERR);
      q_cyc.push_back(cyc);
    end
    prev_dv = DVALID;
  end

  task automatic tick(input logic b);
    RXD = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Drive up to nticks oversample ticks of one frame; noise inverts sample 8 of each data bit.
  task automatic send_wave(input logic [7:0] d, input logic stop_v, input logic noise,
                           input int nticks);
    logic v;
    for (int t = 0; t < nticks && t < 160; t++) begin
      if (t < 16)       v = 1'b0;
      else if (t < 144) v = d[(t - 16) / 16];
      else              v = stop_v;
      if (noise && t >= 16 && t < 144 && (t % 16) == 8) v = ~v;
      tick(v);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic f);
    chk({name, "_count"}, q_dout.size(), 1);
    if (q_dout.size() > 0) begin
      chk({name, "_dout"}, {24'd0, q_dout.pop_front()}, {24'd0, d});
      chk({name, "_ferr"}, {31'd0, q_ferr.pop_front()}, {31'd0, f});
      void'(q_cyc.pop_front());
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       noise;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[4];
  int   s;

  initial begin
    vecs[0] = '{data: 8'h55, stop_v: 1'b1, noise: 1'b0, exp_dout: 8'h55, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop_v: 1'b1, noise: 1'b1, exp_dout: 8'h3C, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hC3, stop_v: 1'b1, noise: 1'b0, exp_dout: 8'hC3, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h01, stop_v: 1'b1, noise: 1'b1, exp_dout: 8'h01, exp_ferr: 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dout",   {24'd0, DOUT},   32'd0);
    chk("rst_dvalid", {31'd0, DVALID}, 32'd0);
    chk("rst_ferr",   {31'd0, FERR},   32'd0);
    chk("rst_busy",   {31'd0, BUSY},   32'd0);
    RST = 1'b0;
    idle(20);

    // Table: clean and noisy frames, each checked for data, FERR and latency.
    for (int i = 0; i < 4; i++) begin
      s = cyc;
      send_wave(vecs[i].data, vecs[i].stop_v, vecs[i].noise, 160);
      idle(8);
      if (q_cyc.size() > 0) chk($sformatf("vec%0d_latency", i), q_cyc[0] - s, 156);
      else chk($sformatf("vec%0d_latency", i), 0, 156);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_ferr);
    end

    // False start: 4 ticks low, then high.
    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("glitch_busy_high", {31'd0, BUSY}, 32'd1);
    idle(16);
    chk("glitch_busy_low", {31'd0, BUSY}, 32'd0);
    chk("glitch_no_dvalid", q_dout.size(), 0);
    idle(8);

    // Back-to-back frames, no idle gap.
    send_wave(8'h00, 1'b1, 1'b0, 160);
    send_wave(8'hFF, 1'b1, 1'b0, 160);
    send_wave(8'h81, 1'b1, 1'b0, 160);
    idle(8);
    chk("b2b_count", q_dout.size(), 3);
    if (q_dout.size() == 3) begin
      chk("b2b_0_dout", {24'd0, q_dout[0]}, 32'h00);
      chk("b2b_1_dout", {24'd0, q_dout[1]}, 32'hFF);
      chk("b2b_2_dout", {24'd0, q_dout[2]}, 32'h81);
      chk("b2b_ferr", {29'd0, q_ferr[0], q_ferr[1], q_ferr[2]}, 32'd0);
    end
    q_dout.delete(); q_ferr.delete(); q_cyc.delete();

    // Framing error followed by a long break.
    send_wave(8'hA3, 1'b0, 1'b0, 160);
    for (int i = 0; i < 30 * 16; i++) tick(1'b0);
    chk("break_busy", {31'd0, BUSY}, 32'd1);
    expect_frame("break", 8'hA3, 1'b1);
    chk("break_no_more_dvalid", q_dout.size(), 0);
    idle(4);
    chk("break_exit_busy", {31'd0, BUSY}, 32'd0);
    idle(20);

    // Asynchronous reset during data bit 4, then a clean frame.
    send_wave(8'h5A, 1'b1, 1'b0, 88);
    chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    RXD = 1'b1;
    RST = 1'b1;
    #1;
    chk("midrst_dout", {24'd0, DOUT}, 32'd0);
    chk("midrst_ferr", {31'd0, FERR}, 32'd0);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(20);
    chk("midrst_no_dvalid", q_dout.size(), 0);
    send_wave(8'h12, 1'b1, 1'b0, 160);
    idle(8);
    expect_frame("after_rst", 8'h12, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
